mii_tx_scheduler: RTL and testbench

MII_TX_SCHEDULER -- requirements
Module: mii_tx_scheduler

---
 rtl/mii_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mii_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_mii_tx_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_pkg.sv
// Shared types and constants for the MII transmit scheduler.
// Optional padding is enabled by defining MII_TX_SCHEDULER_PAD_EN.
package mii_pkg;

    localparam int CNT_W             = 12;
    localparam int MIN_FRAME_NIBBLES = 120;

    typedef logic [3:0]       nibble_t;
    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        PAD,
        GAP
    } state_t;

    // Width of an index able to address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches upward from one above the last winner,
// wrapping, and returns the first active requester as one-hot and index.
module rr_arbiter
    import mii_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] pos;

    // Rotating priority search; the first hit after the last winner wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            pos = IW'((32'(last) + i) % NREQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/mii_tx_scheduler.sv
// MII transmit scheduler: arbitrates NREQ frame sources onto one nibble
// stream, enforcing the inter-frame idle period after every frame.
// Define MII_TX_SCHEDULER_PAD_EN to pad short frames to MIN_FRAME_NIBBLES.
module mii_tx_scheduler
    import mii_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int IFG_NIBBLES   = 32,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ-1:0][3:0] d,
    input  logic [NREQ-1:0]      dv,
    output logic [3:0]           Q,
    output logic                 QV,
    output logic                 busy
);

    localparam int IW   = idx_width(NREQ);
    localparam int TMAX = (GRANT_TIMEOUT > IFG_NIBBLES) ? GRANT_TIMEOUT : IFG_NIBBLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(GRANT_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(IFG_NIBBLES - 1);

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    nibble_t         q, q_n;
    logic            qv, qv_n;
    count_t          cnt, cnt_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [IW-1:0]   last, last_n;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req  (req),
        .last (last),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign Q    = q;
    assign QV   = qv;
    assign busy = (state != IDLE);

    // State and registered outputs; reset truncates any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            q     <= '0;
            qv    <= 1'b0;
            cnt   <= '0;
            tmr   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            q     <= q_n;
            qv    <= qv_n;
            cnt   <= cnt_n;
            tmr   <= tmr_n;
            last  <= last_n;
        end
    end

    // Next-state and next-output decode; Q/QV default to idle so Q is 0 whenever QV is 0.
    // The winner index is stored as 'last' at grant time and used as the active source.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        q_n     = '0;
        qv_n    = 1'b0;
        cnt_n   = cnt;
        tmr_n   = tmr;
        last_n  = last;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_n   = arb_gnt;
                    last_n  = arb_idx;
                    tmr_n   = '0;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (dv[last]) begin
                    q_n     = d[last];
                    qv_n    = 1'b1;
                    cnt_n   = count_t'(1);
                    state_n = SEND;
                end else if (!req[last] || tmr == TMO_LAST) begin
                    gnt_n   = '0;
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            SEND: begin
                if (dv[last]) begin
                    q_n   = d[last];
                    qv_n  = 1'b1;
                    cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
                end else begin
                    gnt_n = '0;
                    tmr_n = '0;
`ifdef MII_TX_SCHEDULER_PAD_EN
                    // The first pad nibble goes out on the exit edge so QV stays contiguous.
                    if (cnt < count_t'(MIN_FRAME_NIBBLES)) begin
                        qv_n    = 1'b1;
                        cnt_n   = cnt + 1'b1;
                        state_n = PAD;
                    end else begin
                        state_n = GAP;
                    end
`else
                    state_n = GAP;
`endif
                end
            end
`ifdef MII_TX_SCHEDULER_PAD_EN
            PAD: begin
                if (cnt >= count_t'(MIN_FRAME_NIBBLES)) begin
                    state_n = GAP;
                end else begin
                    qv_n  = 1'b1;
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Directed self-checking bench for mii_tx_scheduler (NREQ=2, IFG=32, timeout=64).
module tb_mii_tx_scheduler;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic [1:0][3:0] d;
    logic [1:0]      dv;
    logic [3:0]      Q;
    logic            QV;
    logic            busy;

    int total = 0;
    int bad   = 0;

`ifdef MII_TX_SCHEDULER_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    mii_tx_scheduler #(
        .NREQ          (2),
        .IFG_NIBBLES   (32),
        .GRANT_TIMEOUT (64)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .d    (d),
        .dv   (dv),
        .Q    (Q),
        .QV   (QV),
        .busy (busy)
    );

    function automatic logic [3:0] nib(input int k, input int i);
        return 4'((i * 5 + k * 3 + 1) % 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles while busy (bounded) and how many of them had QV high.
    task automatic count_gap(output int g, output int qv_seen);
        g = 0;
        qv_seen = 0;
        while (busy && g < 200) begin
            if (QV) qv_seen++;
            g++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; dv = '0; d = '0;
        #2;
        total++;
        if ({gnt, QV, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got gnt=%b QV=%b busy=%b want 0", gnt, QV, busy);
        end
        total++;
        if (Q !== 4'h0) begin
            bad++; $display("FAIL reset_q: got %h want 0", Q);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_no_req: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_frame();
        int g, qs;
        int errs = 0;
        req = 2'b01; dv = 2'b10; d[1] = 4'hF;
        step();
        total++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            bad++; $display("FAIL single_gnt: got gnt=%b busy=%b want 01/1", gnt, busy);
        end
        for (int i = 0; i < 130; i++) begin
            d[0] = nib(0, i); dv[0] = 1'b1;
            step();
            total++;
            if (QV !== 1'b1 || Q !== nib(0, i)) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL single_nib%0d: got QV=%b Q=%h want 1/%h", i, QV, Q, nib(0, i));
            end
        end
        dv = '0; req = '0;
        step();
        total++;
        if (QV !== 1'b0 || Q !== 4'h0 || gnt !== 2'b00) begin
            bad++; $display("FAIL single_end: got QV=%b Q=%h gnt=%b want 0/0/00", QV, Q, gnt);
        end
        count_gap(g, qs);
        total++;
        if (g !== 32 || qs !== 0) begin
            bad++; $display("FAIL single_gap: got %0d cycles qv=%0d want 32/0", g, qs);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_short_frame();
        int k = 0;
        int g, qs;
        int want = PAD_ON ? 100 : 0;
        req = 2'b01;
        step();
        total++;
        if (gnt !== 2'b01) begin
            bad++; $display("FAIL short_gnt: got %b want 01", gnt);
        end
        for (int i = 0; i < 20; i++) begin
            d[0] = nib(1, i); dv[0] = 1'b1;
            step();
            total++;
            if (QV !== 1'b1 || Q !== nib(1, i)) begin
                bad++; $display("FAIL short_nib%0d: got QV=%b Q=%h want 1/%h", i, QV, Q, nib(1, i));
            end
        end
        dv = '0; req = '0;
        step();
        while (QV && k < 200) begin
            total++;
            if (Q !== 4'h0) begin
                bad++; $display("FAIL short_pad%0d: got Q=%h want 0", k, Q);
            end
            k++;
            step();
        end
        total++;
        if (k !== want) begin
            bad++; $display("FAIL short_pad_len: got %0d want %0d", k, want);
        end
        count_gap(g, qs);
        total++;
        if (g !== 32) begin
            bad++; $display("FAIL short_gap: got %0d want 32", g);
        end
    endtask

    task automatic test_timeout_and_drop();
        int g = 0;
        req = 2'b10; dv = 2'b01; d[0] = 4'hA;
        step();
        total++;
        if (gnt !== 2'b10) begin
            bad++; $display("FAIL tmo_gnt: got %b want 10", gnt);
        end
        while (gnt[1] && g < 200) begin
            if (QV) begin
                bad++; total++; $display("FAIL tmo_qv: got QV=1 want 0");
            end
            g++;
            step();
        end
        total++;
        if (g !== 64) begin
            bad++; $display("FAIL tmo_len: got %0d want 64", g);
        end
        total++;
        if (busy !== 1'b0 || QV !== 1'b0) begin
            bad++; $display("FAIL tmo_idle: got busy=%b QV=%b want 0/0", busy, QV);
        end
        req = 2'b11; dv = '0;
        step();
        total++;
        if (gnt !== 2'b01) begin
            bad++; $display("FAIL tmo_next: got %b want 01", gnt);
        end
        req = 2'b00;
        step();
        total++;
        if (gnt !== 2'b00 || busy !== 1'b0 || QV !== 1'b0) begin
            bad++; $display("FAIL drop_grant: got gnt=%b busy=%b QV=%b want 00/0/0", gnt, busy, QV);
        end
    endtask

    task automatic test_back_to_back();
        int w, g, qs, k, len, idx;
        logic [1:0] exp_g;
        rst = 1'b1; req = 2'b11; dv = '0;
        step();
        rst = 1'b0;
        for (int f = 0; f < 4; f++) begin
            idx   = f % 2;
            exp_g = (idx == 0) ? 2'b01 : 2'b10;
            len   = 10 + f;
            w = 0;
            while (gnt === 2'b00 && w < 10) begin
                w++;
                step();
            end
            total++;
            if (gnt !== exp_g) begin
                bad++; $display("FAIL b2b_order%0d: got %b want %b", f, gnt, exp_g);
            end
            for (int i = 0; i < len; i++) begin
                d[idx] = nib(f + 2, i); dv[idx] = 1'b1;
                d[1 - idx] = 4'hF; dv[1 - idx] = 1'b1;
                step();
                total++;
                if (QV !== 1'b1 || Q !== nib(f + 2, i)) begin
                    bad++; $display("FAIL b2b_nib%0d_%0d: got QV=%b Q=%h want 1/%h", f, i, QV, Q, nib(f + 2, i));
                end
            end
            dv = '0;
            step();
            k = 0;
            while (QV && k < 200) begin
                k++;
                step();
            end
            total++;
            if (k !== (PAD_ON ? 120 - len : 0)) begin
                bad++; $display("FAIL b2b_pad%0d: got %0d want %0d", f, k, PAD_ON ? 120 - len : 0);
            end
            count_gap(g, qs);
            total++;
            if (g !== 32 || qs !== 0) begin
                bad++; $display("FAIL b2b_gap%0d: got %0d qv=%0d want 32/0", f, g, qs);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid_frame();
        req = 2'b01;
        step();
        for (int i = 0; i < 50; i++) begin
            d[0] = nib(7, i); dv[0] = 1'b1;
            step();
        end
        total++;
        if (QV !== 1'b1 || Q !== nib(7, 49)) begin
            bad++; $display("FAIL mid_before: got QV=%b Q=%h want 1/%h", QV, Q, nib(7, 49));
        end
        rst = 1'b1;
        #1;
        total++;
        if ({gnt, QV, busy} !== 4'b0000 || Q !== 4'h0) begin
            bad++; $display("FAIL mid_reset: got gnt=%b QV=%b busy=%b Q=%h want 0", gnt, QV, busy, Q);
        end
        req = 2'b11; dv = '0;
        #2;
        rst = 1'b0;
        step();
        total++;
        if (gnt !== 2'b01 || QV !== 1'b0) begin
            bad++; $display("FAIL mid_rearb: got gnt=%b QV=%b want 01/0", gnt, QV);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_short_frame();
        test_timeout_and_drop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
